// File: rtl/cu_pkg.sv
// Shared types and opcode constants for the control_unit_seq sequencer.
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    TRAP
  } state_t;

  localparam logic [5:0] OP_TRAP = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_MUL  = 6'b010000;
  localparam logic [5:0] OP_DIV  = 6'b010001;
  localparam logic [5:0] OP_GT   = 6'b011000;

  function automatic logic is_long_op(
    input logic [5:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/cu_exec_timer.sv
// Loadable down-counter; last is high in the final execute cycle.
module cu_exec_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/control_unit_seq.sv
// Multi-cycle fetch/decode/execute/write-back sequencer with trap handling.
// Optional feature: define CU_HALF_WORD_EN to drive half_word_mode from IR bit 0.
module control_unit_seq
  import cu_pkg::*;
#(
  parameter int INSTR_WIDTH      = 20,
  parameter int OPCODE_WIDTH     = 6,
  parameter int NUM_REGS         = 6,
  parameter int LONG_EXEC_CYCLES = 4,
  localparam int REG_IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   instr_valid,
  input  logic                   zero_flag,
  input  logic                   div_by_zero_flag,
  input  logic                   mem_violation_flag,
  input  logic                   mem_corruption_flag,
  input  logic                   trap_clear,
  output logic                   fetch_enable,
  output logic                   decode_enable,
  output logic                   execute_enable,
  output logic                   write_back_enable,
  output logic [REG_IDX_W-1:0]   rs1_sel,
  output logic [REG_IDX_W-1:0]   rs2_sel,
  output logic [REG_IDX_W-1:0]   rd_sel,
  output logic                   half_word_mode,
  output logic                   pc_load,
  output logic                   trap_mode_flag,
  output logic                   instr_retired
);

  localparam int TW     = $clog2(LONG_EXEC_CYCLES);
  localparam int RS1_HI = INSTR_WIDTH - OPCODE_WIDTH - 1;
  localparam int RS2_HI = RS1_HI - REG_IDX_W;
  localparam int RD_HI  = RS2_HI - REG_IDX_W;

  state_t                 state;
  state_t                 next;
  logic [INSTR_WIDTH-1:0] ir;
  logic [5:0]             op;
  logic                   fault;
  logic                   take;
  logic                   exec_last;
  logic [TW-1:0]          exec_len;
  logic                   ir_unused;

  assign op        = 6'(ir[INSTR_WIDTH-1 -: OPCODE_WIDTH]);
  assign fault     = mem_violation_flag | mem_corruption_flag;
  assign take      = (state == FETCH) && (next == DECODE);
  assign exec_len  = is_long_op(op) ? TW'(LONG_EXEC_CYCLES - 1) : '0;
  assign ir_unused = ^ir;

  cu_exec_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state == DECODE),
    .load_value(exec_len),
    .last      (exec_last)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      next = FETCH;
      FETCH:     if (instr_valid) next = DECODE;
      DECODE:    next = (op == OP_TRAP) ? TRAP : EXECUTE;
      EXECUTE: begin
        if ((op == OP_DIV) && div_by_zero_flag) begin
          next = TRAP;
        end else if (exec_last) begin
          next = (op == OP_JZ) ? FETCH : WRITEBACK;
        end
      end
      WRITEBACK: next = FETCH;
      TRAP:      if (trap_clear && !fault) next = FETCH;
      default:   next = IDLE;
    endcase
    // Memory faults override every other transition while active.
    if (fault && (state != IDLE) && (state != TRAP)) begin
      next = TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ir                <= '0;
      fetch_enable      <= 1'b0;
      decode_enable     <= 1'b0;
      execute_enable    <= 1'b0;
      write_back_enable <= 1'b0;
      trap_mode_flag    <= 1'b0;
      instr_retired     <= 1'b0;
      pc_load           <= 1'b0;
      rs1_sel           <= '0;
      rs2_sel           <= '0;
      rd_sel            <= '0;
    end else begin
      state             <= next;
      fetch_enable      <= (next == FETCH);
      decode_enable     <= (next == DECODE);
      execute_enable    <= (next == EXECUTE);
      write_back_enable <= (next == WRITEBACK);
      trap_mode_flag    <= (next == TRAP);
      instr_retired     <= (next == WRITEBACK) ||
                           ((state == DECODE) &&
                            (next == EXECUTE) &&
                            (op == OP_JZ));
      // Only a JZ can go straight from EXECUTE back to FETCH.
      pc_load           <= (state == EXECUTE) &&
                           (next == FETCH) && zero_flag;
      if (take) begin
        ir      <= instruction;
        rs1_sel <= instruction[RS1_HI -: REG_IDX_W];
        rs2_sel <= instruction[RS2_HI -: REG_IDX_W];
        rd_sel  <= instruction[RD_HI -: REG_IDX_W];
      end
    end
  end

`ifdef CU_HALF_WORD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      half_word_mode <= 1'b0;
    end else if (take) begin
      half_word_mode <= instruction[0];
    end
  end
`else
  assign half_word_mode = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: per-instruction expected traces vs DUT.
module tb_control_unit_seq;

  localparam int LONG = 4;
  localparam logic [5:0] B_TRAP = 6'd0;
  localparam logic [5:0] B_JZ   = 6'd3;
  localparam logic [5:0] B_AND  = 6'd9;
  localparam logic [5:0] B_MUL  = 6'd16;
  localparam logic [5:0] B_DIV  = 6'd17;
  localparam logic [5:0] B_GT   = 6'd24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [19:0] instruction;
  logic        instr_valid;
  logic        zero_flag;
  logic        div_by_zero_flag;
  logic        mem_violation_flag;
  logic        mem_corruption_flag;
  logic        trap_clear;
  logic        fetch_enable;
  logic        decode_enable;
  logic        execute_enable;
  logic        write_back_enable;
  logic [2:0]  rs1_sel;
  logic [2:0]  rs2_sel;
  logic [2:0]  rd_sel;
  logic        half_word_mode;
  logic        pc_load;
  logic        trap_mode_flag;
  logic        instr_retired;

  control_unit_seq dut (
    .clk                (clk),
    .reset              (reset),
    .instruction        (instruction),
    .instr_valid        (instr_valid),
    .zero_flag          (zero_flag),
    .div_by_zero_flag   (div_by_zero_flag),
    .mem_violation_flag (mem_violation_flag),
    .mem_corruption_flag(mem_corruption_flag),
    .trap_clear         (trap_clear),
    .fetch_enable       (fetch_enable),
    .decode_enable      (decode_enable),
    .execute_enable     (execute_enable),
    .write_back_enable  (write_back_enable),
    .rs1_sel            (rs1_sel),
    .rs2_sel            (rs2_sel),
    .rd_sel             (rd_sel),
    .half_word_mode     (half_word_mode),
    .pc_load            (pc_load),
    .trap_mode_flag     (trap_mode_flag),
    .instr_retired      (instr_retired)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [19:0] ins;
    logic        z;
    logic        dbz;
    logic        mv;
    logic        mc;
    logic        tc;
    logic [16:0] want;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [2:0] m_r1 = '0;
  logic [2:0] m_r2 = '0;
  logic [2:0] m_rd = '0;
  logic       m_hw = 1'b0;
  logic       m_pcl = 1'b0;

  int c_f, c_d, c_e, c_w, c_t, c_ret, c_pcl;

  function automatic logic [16:0] pack(
    input logic f, d, e, w, t, ret, pcl, hw,
    input logic [2:0] a, b, c
  );
    return {f, d, e, w, t, ret, pcl, hw, a, b, c};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    c_f = 0; c_d = 0; c_e = 0; c_w = 0;
    c_t = 0; c_ret = 0; c_pcl = 0;
  endtask

  // Expand one instruction into its expected per-cycle trace.
  // kinds: 0 fetch, 1 decode, 2 execute, 3 write-back.
  task automatic build(
    input logic [19:0] ins,
    input int          w,
    input int          fault_at,
    input int          dbz_at,
    input int          reset_at,
    input logic        z,
    input int          trap_len,
    input bit          stay
  );
    int         kinds[$];
    int         n, cut, fidx, didx, ridx, k;
    bit         trap, jz, nw;
    logic [5:0] op;
    logic [1:0] r;
    logic       hw_new;
    cyc_t       c;
    op = ins[19:14];
    jz = (op == B_JZ);
    n  = (op == B_MUL || op == B_DIV) ? LONG : 1;
`ifdef CU_HALF_WORD_EN
    hw_new = ins[0];
`else
    hw_new = 1'b0;
`endif
    for (int i = 0; i <= w; i++) kinds.push_back(0);
    kinds.push_back(1);
    if (op != B_TRAP) begin
      for (int i = 0; i < n; i++) kinds.push_back(2);
      if (!jz) kinds.push_back(3);
    end
    trap = (op == B_TRAP);
    cut  = kinds.size();
    fidx = -1; didx = -1; ridx = -1;
    if (fault_at >= 0 && fault_at < cut) begin
      fidx = fault_at; cut = fidx + 1; trap = 1;
    end else if (op == B_DIV && dbz_at >= 0 && dbz_at < n) begin
      didx = w + 2 + dbz_at; cut = didx + 1; trap = 1;
    end else if (reset_at >= 0 && reset_at < cut) begin
      ridx = reset_at; cut = ridx + 1; trap = 0;
    end
    for (int i = 0; i < cut; i++) begin
      k     = kinds[i];
      nw    = (i > w);
      c.rst = (i == ridx);
      c.vld = (k == 0) ? (i == w) : rb();
      c.ins = (i == w) ? ins : 20'($urandom);
      c.z   = (k == 2 && jz) ? z : rb();
      c.dbz = (k == 2 && op == B_DIV) ? (i == didx) : rb();
      c.mv  = 1'b0;
      c.mc  = 1'b0;
      if (i == fidx) begin
        r = 2'($urandom_range(1, 3));
        c.mv = r[0];
        c.mc = r[1];
      end
      c.tc   = rb();
      c.want = pack(k == 0, k == 1, k == 2, k == 3, 1'b0,
                    (k == 3) || (k == 2 && jz),
                    (i == 0) && m_pcl,
                    nw ? hw_new : m_hw,
                    nw ? ins[13:11] : m_r1,
                    nw ? ins[10:8] : m_r2,
                    nw ? ins[7:5] : m_rd);
      q.push_back(c);
    end
    if (cut > w + 1) begin
      m_r1 = ins[13:11];
      m_r2 = ins[10:8];
      m_rd = ins[7:5];
      m_hw = hw_new;
    end
    m_pcl = jz && z && !trap && (ridx < 0);
    if (trap) begin
      for (int t = 0; t < trap_len; t++) begin
        c.rst  = 1'b0;
        c.vld  = rb();
        c.ins  = 20'($urandom);
        c.z    = rb();
        c.dbz  = rb();
        c.mv   = stay && t == 0 && trap_len > 1;
        c.mc   = 1'b0;
        c.tc   = (t == trap_len - 1) || c.mv;
        c.want = pack(0, 0, 0, 0, 1, 0, 0, m_hw, m_r1, m_r2, m_rd);
        q.push_back(c);
      end
    end
    if (ridx >= 0) begin
      m_r1 = '0; m_r2 = '0; m_rd = '0;
      m_hw = 1'b0; m_pcl = 1'b0;
      c.rst  = 1'b0;
      c.vld  = rb();
      c.ins  = 20'($urandom);
      c.z    = rb();
      c.dbz  = rb();
      c.mv   = rb();
      c.mc   = rb();
      c.tc   = rb();
      c.want = '0;
      q.push_back(c);
    end
  endtask

  task automatic play();
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset               = q[i].rst;
      instr_valid         = q[i].vld;
      instruction         = q[i].ins;
      zero_flag           = q[i].z;
      div_by_zero_flag    = q[i].dbz;
      mem_violation_flag  = q[i].mv;
      mem_corruption_flag = q[i].mc;
      trap_clear          = q[i].tc;
      @(negedge clk);
      cyc++;
      chk($sformatf("cyc%0d", cyc),
          32'(pack(fetch_enable, decode_enable,
                   execute_enable, write_back_enable,
                   trap_mode_flag, instr_retired, pc_load,
                   half_word_mode, rs1_sel, rs2_sel, rd_sel)),
          32'(q[i].want));
      c_f   += int'(fetch_enable);
      c_d   += int'(decode_enable);
      c_e   += int'(execute_enable);
      c_w   += int'(write_back_enable);
      c_t   += int'(trap_mode_flag);
      c_ret += int'(instr_retired);
      c_pcl += int'(pc_load);
    end
    q.delete();
  endtask

  localparam logic [19:0] I_AND = 20'b00100110010100000010;
  localparam logic [19:0] I_GT  = 20'b01100001110001000010;
  localparam logic [19:0] I_JZ  = 20'b00001100100000000000;
  localparam logic [19:0] I_DIV = {B_DIV, 3'd2, 3'd3, 3'd1, 5'd1};
  localparam logic [19:0] I_MUL = {B_MUL, 3'd5, 3'd1, 3'd4, 5'd0};

  logic [5:0] opl [6] = '{B_TRAP, B_JZ, B_AND, B_MUL, B_DIV, B_GT};

  initial begin
    logic [5:0] op;
    int         w, f, d, r, sel;
    reset = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    zero_flag = 1'b0;
    div_by_zero_flag = 1'b0;
    mem_violation_flag = 1'b0;
    mem_corruption_flag = 1'b0;
    trap_clear = 1'b0;

    @(posedge clk);
    @(negedge clk);
    chk("in_reset", 32'({fetch_enable, decode_enable,
        execute_enable, write_back_enable, trap_mode_flag,
        instr_retired, pc_load, half_word_mode,
        rs1_sel, rs2_sel, rd_sel}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({fetch_enable, decode_enable,
        execute_enable, write_back_enable, trap_mode_flag,
        instr_retired, pc_load, half_word_mode,
        rs1_sel, rs2_sel, rd_sel}), 32'd0);

    clr();
    build(I_AND, 0, -1, -1, -1, 1'b0, 1, 0);
    play();
    chk("and_rs1", 32'(rs1_sel), 32'd4);
    chk("and_rs2", 32'(rs2_sel), 32'd5);
    chk("and_rd", 32'(rd_sel), 32'd0);
    chk("and_fdew", 32'({c_f[3:0], c_d[3:0], c_e[3:0], c_w[3:0]}),
        32'h1111);
    chk("and_retired", 32'(c_ret), 32'd1);

    clr();
    build(I_GT, 3, -1, -1, -1, 1'b0, 1, 0);
    play();
    chk("gt_fetch_cycles", 32'(c_f), 32'd4);
    chk("gt_sel", 32'({rs1_sel, rs2_sel, rd_sel}),
        32'({3'd3, 3'd4, 3'd2}));

    clr();
    build(I_JZ, 0, -1, -1, -1, 1'b1, 1, 0);
    build(I_JZ, 0, -1, -1, -1, 1'b0, 1, 0);
    build(I_AND, 0, -1, -1, -1, 1'b0, 1, 0);
    play();
    chk("jz_pc_load_cycles", 32'(c_pcl), 32'd1);
    chk("jz_no_writeback", 32'(c_w), 32'd1);
    chk("jz_retired", 32'(c_ret), 32'd3);

    clr();
    build(I_DIV, 0, -1, -1, -1, 1'b0, 1, 0);
    play();
    chk("div_exec_cycles", 32'(c_e), 32'd4);

    clr();
    build(I_DIV, 0, -1, 1, -1, 1'b0, 2, 0);
    build(I_AND, 0, -1, -1, -1, 1'b0, 1, 0);
    play();
    chk("div0_exec_cycles", 32'(c_e), 32'd3);
    chk("div0_trap_cycles", 32'(c_t), 32'd2);

    clr();
    build(20'h0, 0, -1, -1, -1, 1'b0, 3, 1);
    play();
    chk("optrap_trap_cycles", 32'(c_t), 32'd3);
    chk("optrap_no_exec", 32'(c_e), 32'd0);

    clr();
    build(I_MUL, 1, 3, -1, -1, 1'b0, 2, 0);
    play();
    chk("fault_exec_cycles", 32'(c_e), 32'd1);
    chk("fault_trap_cycles", 32'(c_t), 32'd2);

    clr();
    build(I_MUL, 0, -1, -1, 3, 1'b0, 1, 0);
    play();
    chk("reset_exec_cycles", 32'(c_e), 32'd2);
    chk("reset_sel_cleared", 32'({rs1_sel, rs2_sel, rd_sel}), 32'd0);

    for (int e = 0; e < 300; e++) begin
      sel = $urandom_range(0, 6);
      op  = (sel == 6) ? 6'($urandom) : opl[sel];
      w   = $urandom_range(0, 3);
      f   = -1; d = -1; r = -1;
      sel = $urandom_range(0, 9);
      if (sel < 2) f = $urandom_range(0, 9);
      else if (sel < 4) d = $urandom_range(0, 3);
      else if (sel == 4) r = $urandom_range(0, 9);
      build({op, 14'($urandom)}, w, f, d, r, rb(),
            $urandom_range(1, 3), bit'(rb()));
      play();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit_seq.md
# control_unit_seq

Parametrised multi-cycle sequencer for the 20-bit CPU, succeeding the fixed four-stage control unit. It steps each instruction through fetch, decode, execute and write-back, and handshakes with instruction memory. Opcode and fault flags drive trap entry and exit. The block also supports variable-latency execute for multiply/divide and a zero-flag jump. It sits between instruction memory and the ALU/register file and drives their stage enables and register selects.

## Interface
- `INSTR_WIDTH`, 20: instruction width.
- `OPCODE_WIDTH`, 6: opcode field width, at `[INSTR_WIDTH-1 -: OPCODE_WIDTH]`.
- `NUM_REGS`, 6: general register count; `REG_IDX_W = $clog2(NUM_REGS)`.
- `LONG_EXEC_CYCLES`, 4: execute cycles for MUL/DIV; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `instruction` in `INSTR_WIDTH`: instruction from memory.
- `instr_valid` in 1: instruction present this cycle.
- `zero_flag`, `div_by_zero_flag`, `mem_violation_flag`, `mem_corruption_flag` in 1 each: ALU/memory status.
- `trap_clear` in 1: leave trap.
- `fetch_enable`, `decode_enable`, `execute_enable`, `write_back_enable` out 1 each: stage enables, one-hot or all zero.
- `rs1_sel`, `rs2_sel`, `rd_sel` out `REG_IDX_W`: register selects.
- `half_word_mode` out 1: ALU half-word mode.
- `pc_load` out 1: take jump to register `rs1_sel`.
- `trap_mode_flag` out 1: in trap.
- `instr_retired` out 1: one-cycle pulse when an instruction completes.

## Operation
- Field layout below the opcode, MSB first:
  - `rs1`, `REG_IDX_W` bits
  - `rs2`, `REG_IDX_W` bits
  - `rd`, `REG_IDX_W` bits
  - bit 0 = half-word select
  - remaining bits ignored
- Layout at default widths:
  - opcode [19:14]
  - rs1 [13:11]
  - rs2 [10:8]
  - rd [7:5]
- States: `IDLE`, `FETCH`, `DECODE`, `EXECUTE`, `WRITEBACK`, `TRAP`.
- `IDLE` → `FETCH` unconditionally on the next cycle.
- `FETCH`: `fetch_enable`=1.
  - Holds until `instr_valid`=1, then the instruction is latched into the instruction register (IR) → `DECODE`.
- `DECODE`: `decode_enable`=1.
  - Select outputs load from the IR.
  - Opcode `OP_TRAP` (0) → `TRAP`; otherwise → `EXECUTE`.
  - Unknown opcodes are treated as ALU ops.
- `EXECUTE`: `execute_enable`=1.
  - 1 cycle, or `LONG_EXEC_CYCLES` for `OP_MUL`/`OP_DIV`, counted by a down-counter.
  - `OP_DIV` with `div_by_zero_flag`=1 in any execute cycle → `TRAP`.
  - `OP_JZ` → `FETCH`, with no write-back. If `zero_flag`=1 in that cycle, `pc_load`=1 for exactly that cycle.
  - All other ops → `WRITEBACK`.
- `WRITEBACK`: `write_back_enable`=1 for 1 cycle → `FETCH`.
- `instr_retired` pulses in the cycle leaving `WRITEBACK`, or leaving `EXECUTE` for `OP_JZ`.
- `TRAP`: all enables 0, `trap_mode_flag`=1. `trap_clear`=1 → `FETCH`.
- Faults: `mem_violation_flag` or `mem_corruption_flag` high in any state other than `IDLE`/`TRAP` → `TRAP` next cycle. This takes precedence over every other transition.

## Timing
- Reset values:
  - state `IDLE`
  - all enables 0
  - selects 0
  - `half_word_mode` 0
  - `pc_load` 0
  - `trap_mode_flag` 0
  - `instr_retired` 0
  - IR 0
- All outputs are registered and Moore-decoded from the state.
- Selects hold their values from `DECODE` until the next `DECODE`.
- Minimum instruction latency with `instr_valid` already high:
  - 4 cycles for a short ALU op
  - 3 + `LONG_EXEC_CYCLES` for MUL/DIV
  - 3 for JZ
- `trap_clear` outside `TRAP` is ignored.
- `trap_clear` together with a fault in `TRAP`: stay in `TRAP`.
- Reset asserted in any state → `IDLE` at the next edge; any multi-cycle count is discarded.

## Configuration
- `CU_HALF_WORD_EN` defined: `half_word_mode` = IR bit 0, loaded in `DECODE`.
- Not defined: `half_word_mode` is tied to 0 and bit 0 is ignored.

## Structure
- Package `cu_pkg` holds:
  - the state enum
  - `OP_TRAP`=6'b000000, `OP_JZ`=6'b000011, `OP_AND`=6'b001001, `OP_MUL`=6'b010000, `OP_DIV`=6'b010001, `OP_GT`=6'b011000
- Sub-module `cu_exec_timer`: loadable down-counter that signals the last execute cycle.

## Test plan
- Reset held 2 cycles, then released → `IDLE`, then `FETCH` with `fetch_enable`=1; all other outputs 0.
- `instruction`=20'b00100110010100000010 (AND) with `instr_valid`=1 → `rs1_sel`=4, `rs2_sel`=5, `rd_sel`=0; enables pulse F, D, E, W in 4 cycles; `instr_retired`=1 once.
- 20'b01100001110001000010 (GT) with `instr_valid` delayed 3 cycles → `fetch_enable` held 4 cycles; then `rs1_sel`=3, `rs2_sel`=4, `rd_sel`=2.
- 20'b00001100100000000000 (JZ) with `zero_flag`=1 → `pc_load`=1 for one cycle with `rs1_sel`=1, no write-back. With `zero_flag`=0 → `pc_load` stays 0.
- DIV with `LONG_EXEC_CYCLES`=4 → `execute_enable` high 4 cycles. Repeat with `div_by_zero_flag`=1 in execute cycle 2 → `TRAP`; `trap_clear` → `FETCH`.
- All-zero instruction → `TRAP` after `DECODE`. Separately, `mem_violation_flag` pulsed during `EXECUTE` → `TRAP` next cycle. Reset pulsed mid-execute → `IDLE`.
